// File: rtl/key_debounce.sv
// key_debounce
// ------------
// Per-key synchronizer, debouncer and event generator for the board push-buttons.
// Raw, bouncing, asynchronous key pins become a clean debounced level plus
// one-cycle press / release / long-press pulses, all in the sys_clk domain.
// Every key channel is fully independent.
//
// Parameters:
//   NUM_KEYS       number of independent key channels
//   DEBOUNCE_CNT   stable cycles needed to accept a change (>= 2)
//   LONG_CNT       cycles held in PRESSED before key_long (> DEBOUNCE_CNT)
//   KEY_ACTIVE_LOW 1: pin at 0 means pressed, 0: pin at 1 means pressed
//
// Ports:
//   sys_clk      in   system clock
//   sys_rst      in   synchronous active-high reset
//   key_in       in   raw asynchronous key pins        [NUM_KEYS]
//   key_state    out  debounced level, 1 = pressed     [NUM_KEYS]
//   key_press    out  one-cycle pulse on accepted press   [NUM_KEYS]
//   key_release  out  one-cycle pulse on accepted release [NUM_KEYS]
//   key_long     out  one-cycle pulse once per hold after LONG_CNT cycles [NUM_KEYS]
//
// All outputs come straight from flops; nothing from key_in reaches them
// combinationally.

module key_debounce #(
    parameter int NUM_KEYS       = 2,
    parameter int DEBOUNCE_CNT   = 1000000,
    parameter int LONG_CNT       = 50000000,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int DW = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam int LW = (LONG_CNT > 2) ? $clog2(LONG_CNT) : 1;

    localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CNT - 1);
    localparam logic [LW-1:0] L_MAX = LW'(LONG_CNT - 1);

    // Inactive pin level: what the synchronizer holds out of reset, and also
    // the XOR mask that normalises the synchronised pin to 1 = pressed.
    localparam logic PIN_IDLE = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    genvar k;
    for (k = 0; k < NUM_KEYS; k++) begin : g_key
        logic          sync1_q;
        logic          sync2_q;
        logic          pressed_raw_s;
        state_t        state_q,      state_d;
        logic [DW-1:0] dcnt_q,       dcnt_d;
        logic [LW-1:0] lcnt_q,       lcnt_d;
        logic          long_fired_q, long_fired_d;
        logic          level_q,      level_d;
        logic          press_q,      press_d;
        logic          release_q,    release_d;
        logic          long_q,       long_d;

        assign pressed_raw_s = sync2_q ^ PIN_IDLE;

        // Next-state and event decode for this key's debounce FSM.
        always_comb begin
            state_d      = state_q;
            dcnt_d       = dcnt_q;
            lcnt_d       = lcnt_q;
            long_fired_d = long_fired_q;
            level_d      = level_q;
            press_d      = 1'b0;
            release_d    = 1'b0;
            long_d       = 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (pressed_raw_s) begin
                        state_d = S_PRESS_WAIT;
                        dcnt_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end

                S_PRESS_WAIT: begin
                    if (!pressed_raw_s) begin
                        // Bounce: give up silently.
                        state_d = S_IDLE;
                    end else if (dcnt_q == D_MAX) begin
                        state_d      = S_PRESSED;
                        press_d      = 1'b1;
                        level_d      = 1'b1;
                        lcnt_d       = '0;
                        long_fired_d = 1'b0;
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end

                S_PRESSED: begin
                    // lcnt saturates, so long_fired is what limits the pulse
                    // to once per hold.
                    if ((lcnt_q == L_MAX) && !long_fired_q) begin
                        long_d       = 1'b1;
                        long_fired_d = 1'b1;
                    end else begin
                        long_fired_d = long_fired_q;
                    end

                    if (!pressed_raw_s) begin
                        state_d = S_RELEASE_WAIT;
                        dcnt_d  = '0;
                    end else if (lcnt_q != L_MAX) begin
                        lcnt_d = lcnt_q + LW'(1);
                    end else begin
                        lcnt_d = lcnt_q;
                    end
                end

                S_RELEASE_WAIT: begin
                    if (pressed_raw_s) begin
                        // Release glitch: resume the hold without a new press;
                        // lcnt and long_fired carry on from where they were.
                        state_d = S_PRESSED;
                    end else if (dcnt_q == D_MAX) begin
                        state_d   = S_IDLE;
                        release_d = 1'b1;
                        level_d   = 1'b0;
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end

                default: begin
                    state_d      = S_IDLE;
                    dcnt_d       = '0;
                    lcnt_d       = '0;
                    long_fired_d = 1'b0;
                    level_d      = 1'b0;
                end
            endcase
        end

        // Synchronizer, FSM state, counters and registered outputs.
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                sync1_q      <= PIN_IDLE;
                sync2_q      <= PIN_IDLE;
                state_q      <= S_IDLE;
                dcnt_q       <= '0;
                lcnt_q       <= '0;
                long_fired_q <= 1'b0;
                level_q      <= 1'b0;
                press_q      <= 1'b0;
                release_q    <= 1'b0;
                long_q       <= 1'b0;
            end else begin
                sync1_q      <= key_in[k];
                sync2_q      <= sync1_q;
                state_q      <= state_d;
                dcnt_q       <= dcnt_d;
                lcnt_q       <= lcnt_d;
                long_fired_q <= long_fired_d;
                level_q      <= level_d;
                press_q      <= press_d;
                release_q    <= release_d;
                long_q       <= long_d;
            end
        end

        assign key_state[k]   = level_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
        assign key_long[k]    = long_q;
    end

endmodule
